// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and defaults for the period meter
package period_meter_pkg;

   localparam int DEFAULT_CNT_W = 32;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } meas_state_e;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with registered-level edge detection
module edge_sync (
   input  logic clk_i,
   input  logic reset,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Both edges come from the same flop pair, so rise and fall share one latency.
   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~prev_q;
   assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of an asynchronous signal in clk_i cycles
module period_meter
   import period_meter_pkg::*;
#(
   parameter int          CNT_W       = DEFAULT_CNT_W,
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic             sig_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             timeout_o,
   output logic             locked_o
);

   if (TIMEOUT_CYC == 0 || (64'(TIMEOUT_CYC) >> CNT_W) != 64'd0) begin : g_cfg_check
      $error("period_meter: TIMEOUT_CYC must be nonzero and fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   logic sig_rise;
   logic sig_fall;
   logic unused_level;

   edge_sync u_edge_sync (
      .clk_i   (clk_i),
      .reset   (reset),
      .d_i     (sig_i),
      .level_o (unused_level),
      .rise_o  (sig_rise),
      .fall_o  (sig_fall)
   );

   meas_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] high_cap_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_q;
   logic             valid_q;
   logic             timeout_q;
   logic             locked_q;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         high_cap_q <= '0;
         period_q   <= '0;
         high_q     <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sig_rise) begin
                  state_q    <= ST_MEASURE;
                  cnt_q      <= ONE;
                  high_cap_q <= '0;
                  locked_q   <= 1'b1;
               end
            end
            ST_MEASURE: begin
               // A rise landing on the timeout cycle still closes the period normally.
               if (sig_rise) begin
                  period_q   <= cnt_q;
                  high_q     <= high_cap_q;
                  cnt_q      <= ONE;
                  high_cap_q <= '0;
                  valid_q    <= 1'b1;
                  timeout_q  <= 1'b0;
               end else if (cnt_q == TIMEOUT_CNT) begin
                  state_q    <= ST_IDLE;
                  cnt_q      <= '0;
                  high_cap_q <= '0;
                  period_q   <= '0;
                  high_q     <= '0;
                  timeout_q  <= 1'b1;
                  locked_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + ONE;
                  if (sig_fall) begin
                     high_cap_q <= cnt_q;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign period_o  = period_q;
   assign high_o    = high_q;
   assign valid_o   = valid_q;
   assign timeout_o = timeout_q;
   assign locked_o  = locked_q;

endmodule
